// File: rtl/uart_alu_pkg.sv
// Shared types and defaults for the UART-to-ALU frame sequencer.
package uart_alu_pkg;

    localparam int unsigned DATA_BITS_DEFAULT   = 8;
    localparam int unsigned OPCODE_BITS_DEFAULT = 6;
    localparam int unsigned FRAME_CNT_BITS      = 8;

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SEND   = 3'd4
    } seq_state_e;

    // States in which an RX byte may be popped.
    function automatic logic is_get_state(input seq_state_e s);
        return (s == GET_A) || (s == GET_B) || (s == GET_OP);
    endfunction

    // States in which a partial frame is open and the inter-byte timer runs.
    function automatic logic is_mid_frame(input seq_state_e s);
        return (s == GET_B) || (s == GET_OP);
    endfunction

endpackage

// File: rtl/uart_alu_sequencer_if.sv
// FIFO and ALU connections of the sequencer; master is the sequencer side.
interface uart_alu_sequencer_if
    import uart_alu_pkg::*;
#(
    parameter int unsigned DATA_BITS   = DATA_BITS_DEFAULT,
    parameter int unsigned OPCODE_BITS = OPCODE_BITS_DEFAULT
);

    logic                   i_rx_empty;
    logic [DATA_BITS-1:0]   i_r_data;
    logic                   i_tx_full;
    logic [DATA_BITS-1:0]   i_alu_result;
    logic                   o_rd_uart;
    logic                   o_wr_uart;
    logic [DATA_BITS-1:0]   o_w_data;
    logic [DATA_BITS-1:0]   o_op_a;
    logic [DATA_BITS-1:0]   o_op_b;
    logic [OPCODE_BITS-1:0] o_op_code;

    modport master (
        input  i_rx_empty,
        input  i_r_data,
        input  i_tx_full,
        input  i_alu_result,
        output o_rd_uart,
        output o_wr_uart,
        output o_w_data,
        output o_op_a,
        output o_op_b,
        output o_op_code
    );

    modport slave (
        output i_rx_empty,
        output i_r_data,
        output i_tx_full,
        output i_alu_result,
        input  o_rd_uart,
        input  o_wr_uart,
        input  o_w_data,
        input  o_op_a,
        input  o_op_b,
        input  o_op_code
    );

endinterface

// File: rtl/frame_timeout_counter.sv
// Inter-byte watchdog: counts empty cycles inside a frame and flags expiry.
module frame_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_BITS       = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire,
    output logic running
);

    localparam logic [CNT_BITS-1:0] LAST_COUNT = CNT_BITS'(TIMEOUT_CYCLES - 1);

    logic [CNT_BITS-1:0] count;

    // A byte popped on the expiry cycle wins, so clear masks expire.
    assign expire  = enable && !clear && (count == LAST_COUNT);
    assign running = (count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/uart_alu_sequencer.sv
// Pops A, B, opcode from the RX FIFO, runs them through the ALU and pushes the
// result to the TX FIFO; a stalled partial frame is dropped after a timeout.
module uart_alu_sequencer
    import uart_alu_pkg::*;
#(
    parameter int unsigned DATA_BITS      = DATA_BITS_DEFAULT,
    parameter int unsigned OPCODE_BITS    = OPCODE_BITS_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_BITS       = 20
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    uart_alu_sequencer_if.master      bus,
    output logic                      o_busy,
    output logic                      o_timeout,
    output logic [FRAME_CNT_BITS-1:0] o_frame_cnt
);

    seq_state_e           state;
    logic [DATA_BITS-1:0] rx_byte;
    logic                 pop;
    logic                 push;
    logic                 tmo_enable;
    logic                 tmo_expire;
    logic                 tmo_running;

    assign rx_byte = bus.i_r_data;

    // FIFO strobes are combinational so a byte moves on the edge it is offered.
    assign pop        = is_get_state(state) && !bus.i_rx_empty;
    assign push       = (state == SEND) && !bus.i_tx_full;
    assign tmo_enable = is_mid_frame(state) && bus.i_rx_empty;

    assign bus.o_rd_uart = pop;
    assign bus.o_wr_uart = push;
    assign o_busy        = (state != GET_A) || tmo_running;

    frame_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_BITS       (CNT_BITS)
    ) u_timeout (
        .clk     (i_clk),
        .reset   (i_reset),
        .clear   (pop),
        .enable  (tmo_enable),
        .expire  (tmo_expire),
        .running (tmo_running)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= GET_A;
            bus.o_op_a    <= '0;
            bus.o_op_b    <= '0;
            bus.o_op_code <= '0;
            bus.o_w_data  <= '0;
            o_frame_cnt   <= '0;
            o_timeout     <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            case (state)
                GET_A: begin
                    if (pop) begin
                        bus.o_op_a <= rx_byte;
                        state      <= GET_B;
                    end
                end
                GET_B: begin
                    if (pop) begin
                        bus.o_op_b <= rx_byte;
                        state      <= GET_OP;
                    end else if (tmo_expire) begin
                        o_timeout <= 1'b1;
                        state     <= GET_A;
                    end
                end
                GET_OP: begin
                    if (pop) begin
                        bus.o_op_code <= rx_byte[OPCODE_BITS-1:0];
                        state         <= EXEC;
                    end else if (tmo_expire) begin
                        o_timeout <= 1'b1;
                        state     <= GET_A;
                    end
                end
                EXEC: begin
                    // Operands have been stable since capture, so the ALU output is settled.
                    bus.o_w_data <= bus.i_alu_result;
                    state        <= SEND;
                end
                SEND: begin
                    if (push) begin
                        o_frame_cnt <= o_frame_cnt + FRAME_CNT_BITS'(1);
                        state       <= GET_A;
                    end
                end
                default: begin
                    state <= GET_A;
                end
            endcase
        end
    end

endmodule
